// File: rtl/axis_demultiplexeur.sv
// Receive-side AXI-Stream frame steering: one input, four outputs (heartbeat1..3, SFP).
// Route picked from tdest on the first beat and held to tlast; one shared output register.
module axis_demultiplexeur #(
  parameter int AXIS_DATA_WIDTH = 64,
  parameter int AXIS_KEEP_WIDTH = AXIS_DATA_WIDTH / 8,
  parameter int AXIS_ID_WIDTH   = 1,
  parameter int AXIS_DEST_WIDTH = 9,
  parameter int AXIS_USER_WIDTH = 97,
  parameter int HB1_DEST        = 1,
  parameter int HB2_DEST        = 2,
  parameter int HB3_DEST        = 3,
  parameter int COUNT_WIDTH     = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       drop_unmatched,

  input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [AXIS_KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                       s_axis_tvalid,
  output logic                       s_axis_tready,
  input  logic                       s_axis_tlast,
  input  logic [AXIS_USER_WIDTH-1:0] s_axis_tuser,
  input  logic [AXIS_ID_WIDTH-1:0]   s_axis_tid,
  input  logic [AXIS_DEST_WIDTH-1:0] s_axis_tdest,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_heartbeat1_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_heartbeat1_tkeep,
  output logic                       m_axis_heartbeat1_tvalid,
  input  logic                       m_axis_heartbeat1_tready,
  output logic                       m_axis_heartbeat1_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_heartbeat1_tuser,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_heartbeat1_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_heartbeat1_tdest,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_heartbeat2_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_heartbeat2_tkeep,
  output logic                       m_axis_heartbeat2_tvalid,
  input  logic                       m_axis_heartbeat2_tready,
  output logic                       m_axis_heartbeat2_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_heartbeat2_tuser,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_heartbeat2_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_heartbeat2_tdest,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_heartbeat3_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_heartbeat3_tkeep,
  output logic                       m_axis_heartbeat3_tvalid,
  input  logic                       m_axis_heartbeat3_tready,
  output logic                       m_axis_heartbeat3_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_heartbeat3_tuser,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_heartbeat3_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_heartbeat3_tdest,

  output logic [AXIS_DATA_WIDTH-1:0] m_axis_SFP_tdata,
  output logic [AXIS_KEEP_WIDTH-1:0] m_axis_SFP_tkeep,
  output logic                       m_axis_SFP_tvalid,
  input  logic                       m_axis_SFP_tready,
  output logic                       m_axis_SFP_tlast,
  output logic [AXIS_USER_WIDTH-1:0] m_axis_SFP_tuser,
  output logic [AXIS_ID_WIDTH-1:0]   m_axis_SFP_tid,
  output logic [AXIS_DEST_WIDTH-1:0] m_axis_SFP_tdest,

  output logic [COUNT_WIDTH-1:0]     frame_count_heartbeat1,
  output logic [COUNT_WIDTH-1:0]     frame_count_heartbeat2,
  output logic [COUNT_WIDTH-1:0]     frame_count_heartbeat3,
  output logic [COUNT_WIDTH-1:0]     frame_count_SFP,
  output logic [COUNT_WIDTH-1:0]     drop_count,
  output logic                       frame_active
);

  // state | meaning
  // IDLE  | next accepted beat is a first beat; route decoded from its tdest
  // FRAME | mid-frame; beats follow sel_reg/drop_reg until tlast
  typedef enum logic {IDLE, FRAME} state_t;

  localparam logic [AXIS_DEST_WIDTH-1:0] HB1_D = AXIS_DEST_WIDTH'(HB1_DEST);
  localparam logic [AXIS_DEST_WIDTH-1:0] HB2_D = AXIS_DEST_WIDTH'(HB2_DEST);
  localparam logic [AXIS_DEST_WIDTH-1:0] HB3_D = AXIS_DEST_WIDTH'(HB3_DEST);
  localparam logic [COUNT_WIDTH-1:0]     CNT_ONE = {{(COUNT_WIDTH-1){1'b0}}, 1'b1};

  state_t                     state;
  logic [1:0]                 sel_reg;
  logic                       drop_reg;

  logic                       out_valid;
  logic [1:0]                 out_sel;
  logic [AXIS_DATA_WIDTH-1:0] out_tdata;
  logic [AXIS_KEEP_WIDTH-1:0] out_tkeep;
  logic                       out_tlast;
  logic [AXIS_USER_WIDTH-1:0] out_tuser;
  logic [AXIS_ID_WIDTH-1:0]   out_tid;
  logic [AXIS_DEST_WIDTH-1:0] out_tdest;

  logic [COUNT_WIDTH-1:0]     frame_cnt [4];
  logic [COUNT_WIDTH-1:0]     drop_cnt;

  logic [3:0] m_ready_vec;
  logic       out_ready;
  logic       unload;
  logic       accept;
  logic       load;
  logic [1:0] new_sel;
  logic       new_drop;
  logic [1:0] cur_sel;
  logic       cur_drop;

  assign m_ready_vec = {m_axis_SFP_tready, m_axis_heartbeat3_tready,
                        m_axis_heartbeat2_tready, m_axis_heartbeat1_tready};
  assign out_ready   = m_ready_vec[out_sel];
  assign unload      = out_valid && out_ready;

  // Beats of a dropped frame bypass the register; first beats never look at their own route.
  assign s_axis_tready = !rst && (((state == FRAME) && drop_reg) || !out_valid || out_ready);
  assign accept        = s_axis_tvalid && s_axis_tready;

  always_comb begin
    new_sel  = 2'd3;
    new_drop = 1'b0;
    if (s_axis_tdest == HB1_D) begin
      new_sel = 2'd0;
    end else if (s_axis_tdest == HB2_D) begin
      new_sel = 2'd1;
    end else if (s_axis_tdest == HB3_D) begin
      new_sel = 2'd2;
    end else begin
      new_drop = drop_unmatched;
    end
  end

  assign cur_sel  = (state == IDLE) ? new_sel  : sel_reg;
  assign cur_drop = (state == IDLE) ? new_drop : drop_reg;
  assign load     = accept && !cur_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sel_reg   <= 2'd0;
      drop_reg  <= 1'b0;
      out_valid <= 1'b0;
      out_sel   <= 2'd0;
      out_tdata <= '0;
      out_tkeep <= '0;
      out_tlast <= 1'b0;
      out_tuser <= '0;
      out_tid   <= '0;
      out_tdest <= '0;
      for (int i = 0; i < 4; i++) frame_cnt[i] <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept) begin
        if (state == IDLE) begin
          sel_reg  <= new_sel;
          drop_reg <= new_drop;
          if (!s_axis_tlast) state <= FRAME;
        end else if (s_axis_tlast) begin
          state <= IDLE;
        end
      end

      if (load) begin
        out_valid <= 1'b1;
        out_sel   <= cur_sel;
        out_tdata <= s_axis_tdata;
        out_tkeep <= s_axis_tkeep;
        out_tlast <= s_axis_tlast;
        out_tuser <= s_axis_tuser;
        out_tid   <= s_axis_tid;
        out_tdest <= s_axis_tdest;
      end else if (unload) begin
        out_valid <= 1'b0;
      end

      if (unload && out_tlast) frame_cnt[out_sel] <= frame_cnt[out_sel] + CNT_ONE;
      if (accept && cur_drop && s_axis_tlast) drop_cnt <= drop_cnt + CNT_ONE;
    end
  end

  assign m_axis_heartbeat1_tvalid = out_valid && (out_sel == 2'd0);
  assign m_axis_heartbeat2_tvalid = out_valid && (out_sel == 2'd1);
  assign m_axis_heartbeat3_tvalid = out_valid && (out_sel == 2'd2);
  assign m_axis_SFP_tvalid        = out_valid && (out_sel == 2'd3);

  assign m_axis_heartbeat1_tdata = out_tdata;
  assign m_axis_heartbeat1_tkeep = out_tkeep;
  assign m_axis_heartbeat1_tlast = out_tlast;
  assign m_axis_heartbeat1_tuser = out_tuser;
  assign m_axis_heartbeat1_tid   = out_tid;
  assign m_axis_heartbeat1_tdest = out_tdest;

  assign m_axis_heartbeat2_tdata = out_tdata;
  assign m_axis_heartbeat2_tkeep = out_tkeep;
  assign m_axis_heartbeat2_tlast = out_tlast;
  assign m_axis_heartbeat2_tuser = out_tuser;
  assign m_axis_heartbeat2_tid   = out_tid;
  assign m_axis_heartbeat2_tdest = out_tdest;

  assign m_axis_heartbeat3_tdata = out_tdata;
  assign m_axis_heartbeat3_tkeep = out_tkeep;
  assign m_axis_heartbeat3_tlast = out_tlast;
  assign m_axis_heartbeat3_tuser = out_tuser;
  assign m_axis_heartbeat3_tid   = out_tid;
  assign m_axis_heartbeat3_tdest = out_tdest;

  assign m_axis_SFP_tdata = out_tdata;
  assign m_axis_SFP_tkeep = out_tkeep;
  assign m_axis_SFP_tlast = out_tlast;
  assign m_axis_SFP_tuser = out_tuser;
  assign m_axis_SFP_tid   = out_tid;
  assign m_axis_SFP_tdest = out_tdest;

  assign frame_count_heartbeat1 = frame_cnt[0];
  assign frame_count_heartbeat2 = frame_cnt[1];
  assign frame_count_heartbeat3 = frame_cnt[2];
  assign frame_count_SFP        = frame_cnt[3];
  assign drop_count             = drop_cnt;
  assign frame_active           = (state == FRAME);

endmodule

// File: tb/tb_axis_demultiplexeur.sv
// Bench for axis_demultiplexeur: route-decode vector table, directed corner sequences,
// and random traffic checked against a per-output frame scoreboard.
module tb_axis_demultiplexeur;

  typedef struct packed {
    logic [63:0] d;
    logic [7:0]  k;
    logic        l;
    logic [96:0] u;
    logic        id;
    logic [8:0]  dest;
  } beat_t;

  typedef struct {
    logic [8:0] dest;
    logic       du;
    logic [3:0] exp_valid;
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic du  = 1'b0;

  logic [63:0] s_tdata  = '0;
  logic [7:0]  s_tkeep  = '0;
  logic        s_tvalid = 1'b0;
  logic        s_tready;
  logic        s_tlast  = 1'b0;
  logic [96:0] s_tuser  = '0;
  logic        s_tid    = 1'b0;
  logic [8:0]  s_tdest  = '0;

  logic [3:0]  m_rdy = 4'hF;
  logic [3:0]  mv;
  logic [63:0] md [4];
  logic [7:0]  mk [4];
  logic        ml [4];
  logic [96:0] mu [4];
  logic        mi [4];
  logic [8:0]  mdst [4];
  beat_t       ob [4];

  logic [31:0] fc [4];
  logic [31:0] dc;
  logic        f_active;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // scoreboard state
  beat_t q [4][$];
  int    ord [$];
  bit    in_frame = 0;
  int    cur_route = 0;
  int    exp_fc [4] = '{0, 0, 0, 0};
  int    exp_drop = 0;
  int    frames_sent = 0;
  bit    rand_rdy = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  axis_demultiplexeur dut (
    .clk(clk), .rst(rst), .drop_unmatched(du),
    .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
    .s_axis_tid(s_tid), .s_axis_tdest(s_tdest),
    .m_axis_heartbeat1_tdata(md[0]), .m_axis_heartbeat1_tkeep(mk[0]),
    .m_axis_heartbeat1_tvalid(mv[0]), .m_axis_heartbeat1_tready(m_rdy[0]),
    .m_axis_heartbeat1_tlast(ml[0]), .m_axis_heartbeat1_tuser(mu[0]),
    .m_axis_heartbeat1_tid(mi[0]), .m_axis_heartbeat1_tdest(mdst[0]),
    .m_axis_heartbeat2_tdata(md[1]), .m_axis_heartbeat2_tkeep(mk[1]),
    .m_axis_heartbeat2_tvalid(mv[1]), .m_axis_heartbeat2_tready(m_rdy[1]),
    .m_axis_heartbeat2_tlast(ml[1]), .m_axis_heartbeat2_tuser(mu[1]),
    .m_axis_heartbeat2_tid(mi[1]), .m_axis_heartbeat2_tdest(mdst[1]),
    .m_axis_heartbeat3_tdata(md[2]), .m_axis_heartbeat3_tkeep(mk[2]),
    .m_axis_heartbeat3_tvalid(mv[2]), .m_axis_heartbeat3_tready(m_rdy[2]),
    .m_axis_heartbeat3_tlast(ml[2]), .m_axis_heartbeat3_tuser(mu[2]),
    .m_axis_heartbeat3_tid(mi[2]), .m_axis_heartbeat3_tdest(mdst[2]),
    .m_axis_SFP_tdata(md[3]), .m_axis_SFP_tkeep(mk[3]),
    .m_axis_SFP_tvalid(mv[3]), .m_axis_SFP_tready(m_rdy[3]),
    .m_axis_SFP_tlast(ml[3]), .m_axis_SFP_tuser(mu[3]),
    .m_axis_SFP_tid(mi[3]), .m_axis_SFP_tdest(mdst[3]),
    .frame_count_heartbeat1(fc[0]), .frame_count_heartbeat2(fc[1]),
    .frame_count_heartbeat3(fc[2]), .frame_count_SFP(fc[3]),
    .drop_count(dc), .frame_active(f_active)
  );

  for (genvar g = 0; g < 4; g++) begin : g_ob
    assign ob[g] = {md[g], mk[g], ml[g], mu[g], mi[g], mdst[g]};
  end

  task automatic chk(input string name, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  function automatic int route_of(input logic [8:0] d, input logic drop_bit);
    if (d == 9'd1) return 0;
    if (d == 9'd2) return 1;
    if (d == 9'd3) return 2;
    return drop_bit ? 4 : 3;
  endfunction

  // Reference model: observes handshakes at the falling edge, before the rising edge that commits them.
  always @(negedge clk) begin
    logic [3:0] exp_mv;
    logic       exp_rdy;
    if (rst) begin
      chk("rst_s_tready", s_tready, 0);
      chk("rst_tvalid", mv, 0);
      for (int i = 0; i < 4; i++) q[i].delete();
      ord.delete();
      in_frame = 0;
      exp_fc = '{0, 0, 0, 0};
      exp_drop = 0;
      frames_sent = 0;
    end else begin
      exp_mv  = (ord.size() != 0) ? (4'b0001 << ord[0]) : 4'b0000;
      exp_rdy = (in_frame && cur_route == 4) || (ord.size() == 0) ||
                ((ord.size() != 0) && m_rdy[ord[0]]);
      chk("tvalid_vec", mv, exp_mv);
      chk("s_tready", s_tready, exp_rdy);
      for (int x = 0; x < 4; x++) begin
        if (mv[x] && m_rdy[x]) begin
          if (q[x].size() == 0) begin
            chk($sformatf("unexpected_beat_out%0d", x), 1, 0);
          end else begin
            chk($sformatf("beat_out%0d", x), ob[x], q[x].pop_front());
            void'(ord.pop_front());
          end
        end
      end
      if (s_tvalid && s_tready) begin
        if (!in_frame) cur_route = route_of(s_tdest, du);
        in_frame = !s_tlast;
        if (cur_route != 4) begin
          q[cur_route].push_back({s_tdata, s_tkeep, s_tlast, s_tuser, s_tid, s_tdest});
          ord.push_back(cur_route);
          if (s_tlast) exp_fc[cur_route]++;
        end else if (s_tlast) begin
          exp_drop++;
        end
        if (s_tlast) frames_sent++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_beat(input logic [8:0] dest, input logic last, input logic drop_bit);
    bit got = 0;
    s_tdata  = {$urandom, $urandom};
    s_tkeep  = 8'($urandom);
    s_tuser  = 97'({$urandom, $urandom, $urandom, $urandom});
    s_tid    = 1'($urandom);
    s_tdest  = dest;
    s_tlast  = last;
    du       = drop_bit;
    s_tvalid = 1'b1;
    for (int k = 0; k < 500 && !got; k++) begin
      #1;
      if (s_tready) got = 1;
      tick();
    end
    s_tvalid = 1'b0;
    if (!got) chk("send_timeout", 0, 1);
  endtask

  task automatic drain();
    bit done = 0;
    m_rdy = 4'hF;
    for (int k = 0; k < 100 && !done; k++) begin
      if (ord.size() == 0) done = 1;
      else tick();
    end
    if (!done) chk("drain_timeout", 0, 1);
  endtask

  task automatic check_counters(input string tag);
    for (int x = 0; x < 4; x++) chk($sformatf("%s_frame_count%0d", tag, x), fc[x], exp_fc[x]);
    chk({tag, "_drop_count"}, dc, exp_drop);
  endtask

  vec_t vecs [9];

  initial begin
    int c0;
    vecs[0] = '{9'd1,   1'b0, 4'b0001};
    vecs[1] = '{9'd2,   1'b0, 4'b0010};
    vecs[2] = '{9'd3,   1'b0, 4'b0100};
    vecs[3] = '{9'd0,   1'b0, 4'b1000};
    vecs[4] = '{9'h55,  1'b0, 4'b1000};
    vecs[5] = '{9'h1FF, 1'b1, 4'b0000};
    vecs[6] = '{9'd1,   1'b1, 4'b0001};
    vecs[7] = '{9'd0,   1'b1, 4'b0000};
    vecs[8] = '{9'd3,   1'b1, 4'b0100};

    tick();
    tick();
    for (int x = 0; x < 4; x++) chk($sformatf("reset_frame_count%0d", x), fc[x], 0);
    chk("reset_drop_count", dc, 0);
    chk("reset_frame_active", f_active, 0);
    rst = 1'b0;
    tick();

    // 3-beat frame to heartbeat2, one beat per cycle
    c0 = cyc;
    send_beat(9'd2, 1'b0, 1'b0);
    chk("hb2_latency_valid", mv, 4'b0010);
    chk("hb2_frame_active", f_active, 1);
    send_beat(9'd2, 1'b0, 1'b0);
    send_beat(9'd2, 1'b1, 1'b0);
    chk("hb2_throughput_cycles", cyc - c0, 3);
    chk("hb2_idle_after_last", f_active, 0);
    drain();
    chk("hb2_frame_count", fc[1], 1);
    check_counters("t1");

    // later beat tdest is ignored
    send_beat(9'd1, 1'b0, 1'b0);
    send_beat(9'd3, 1'b0, 1'b1);
    send_beat(9'd3, 1'b1, 1'b0);
    drain();
    chk("hb1_sticky_route_count", fc[0], 1);
    chk("hb3_untouched", fc[2], 0);

    // unmatched tdest: SFP then drop
    send_beat(9'h55, 1'b1, 1'b0);
    drain();
    chk("sfp_count", fc[3], 1);
    send_beat(9'h55, 1'b0, 1'b1);
    chk("drop_no_valid", mv, 0);
    send_beat(9'h55, 1'b0, 1'b0);
    send_beat(9'h55, 1'b1, 1'b0);
    drain();
    chk("drop_count", dc, 1);
    check_counters("t3");

    // hb3 then SFP with SFP blocked
    m_rdy = 4'b0111;
    c0 = cyc;
    send_beat(9'd3, 1'b0, 1'b0);
    send_beat(9'd3, 1'b1, 1'b0);
    send_beat(9'h40, 1'b1, 1'b0);
    chk("b2b_cycles", cyc - c0, 3);
    for (int k = 0; k < 3; k++) begin
      chk("stall_s_tready", s_tready, 0);
      chk("stall_sfp_valid", mv, 4'b1000);
      tick();
    end
    chk("hb3_done_during_stall", fc[2], 1);
    m_rdy = 4'hF;
    drain();
    chk("sfp_after_stall", fc[3], 2);
    check_counters("t4");

    // table-driven route decode, single-beat frames
    for (int v = 0; v < 9; v++) begin
      send_beat(vecs[v].dest, 1'b1, vecs[v].du);
      chk($sformatf("vec%0d_route", v), mv, vecs[v].exp_valid);
      drain();
    end
    check_counters("vec");

    // random traffic
    rand_rdy = 1;
    fork
      begin
        for (int f = 0; f < 200; f++) begin
          int len;
          logic [8:0] d0;
          len = $urandom_range(1, 4);
          case ($urandom_range(0, 4))
            0: d0 = 9'd1;
            1: d0 = 9'd2;
            2: d0 = 9'd3;
            3: d0 = 9'h55;
            default: d0 = 9'($urandom);
          endcase
          for (int b = 0; b < len; b++) begin
            int gap;
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) tick();
            send_beat((b == 0) ? d0 : 9'($urandom), (b == len - 1), 1'($urandom));
          end
        end
        rand_rdy = 0;
      end
      begin
        while (rand_rdy) begin
          @(posedge clk);
          #1;
          for (int x = 0; x < 4; x++) m_rdy[x] = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
    tick();
    check_counters("rand");
    chk("rand_total_frames", fc[0] + fc[1] + fc[2] + fc[3] + dc, 32'(frames_sent));
    chk("rand_scoreboard_empty", q[0].size() + q[1].size() + q[2].size() + q[3].size(), 0);

    // reset in the middle of a 4-beat frame
    send_beat(9'd2, 1'b0, 1'b0);
    send_beat(9'd2, 1'b0, 1'b0);
    rst = 1'b1;
    #1;
    for (int x = 0; x < 4; x++) chk($sformatf("midrst_frame_count%0d", x), fc[x], 0);
    chk("midrst_drop_count", dc, 0);
    chk("midrst_tvalid", mv, 0);
    chk("midrst_frame_active", f_active, 0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    send_beat(9'd1, 1'b1, 1'b0);
    chk("post_rst_route", mv, 4'b0001);
    drain();
    chk("post_rst_hb1", fc[0], 1);
    chk("post_rst_hb2", fc[1], 0);
    check_counters("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
